// File: rtl/ysyx_regfile_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_regfile_pkg
//   Shared sizing and types for the scoreboarded GPR file.
//   NR_REG : architectural registers (reg 0 reads as zero, never counted)
//   DATA_W : register width
//   NR_RD  : number of combinational read ports
//   CNT_W  : busy-counter width; up to 2**CNT_W-1 in-flight writers per reg
// ----------------------------------------------------------------------------
package ysyx_regfile_pkg;

    localparam int NR_REG = 32;
    localparam int DATA_W = 32;
    localparam int NR_RD  = 2;
    localparam int CNT_W  = 2;
    localparam int AW     = $clog2(NR_REG);

    typedef logic [AW-1:0]     reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

    localparam sb_cnt_t CNT_ONE = sb_cnt_t'(1);
    localparam sb_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/ysyx_regfile_sb_counter.sv
// ----------------------------------------------------------------------------
// ysyx_sb_counter
//   In-flight writer counter for one register.
//   clk, rst : clock, synchronous active-high reset
//   inc      : an accepted issue targets this register
//   dec      : a writeback targets this register
//   flush    : drop all pending writers (counter cleared next cycle)
//   cnt      : current count
//   busy     : cnt != 0
//   full     : cnt == maximum
// ----------------------------------------------------------------------------
module ysyx_sb_counter
    import ysyx_regfile_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    inc,
    input  logic    dec,
    input  logic    flush,
    output sb_cnt_t cnt,
    output logic    busy,
    output logic    full
);

    sb_cnt_t cnt_q;
    sb_cnt_t cnt_d;

    // Simultaneous inc+dec cancels; decrement saturates at 0 and increment
    // never wraps past the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case ({inc, dec})
                2'b10: if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                2'b01: if (cnt_q != '0)      cnt_d = cnt_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A writeback with no pending writer means the pipeline lost track.
    always_ff @(posedge clk) begin
        if (!rst && !flush && dec && !inc && (cnt_q == '0)) begin
            $error("ysyx_sb_counter: writeback underflow");
        end
    end
`endif

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);
    assign full = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ysyx_regfile_sb.sv
// ----------------------------------------------------------------------------
// ysyx_regfile_sb
//   GPR file with per-register scoreboard. Combinational read ports bypass a
//   same-cycle writeback; each register keeps a count of in-flight writers.
//   clk, rst   : clock, synchronous active-high reset (overrides wb/flush)
//   rs_addr    : packed read addresses, port p at [p*AW +: AW]
//   rs_data    : packed read data, port p at [p*DATA_W +: DATA_W]
//   rs_busy    : per port, read value still has a pending writer
//   iss_valid  : issue of an instruction writing iss_rd
//   iss_rd     : issue destination
//   iss_ready  : issue accepted when iss_valid & iss_ready
//   wb_valid   : writeback strobe
//   wb_rd      : writeback destination
//   wb_data    : writeback data
//   flush      : clear all counters, drop same-cycle issue, keep wb data
//   sb_idle    : every busy counter is zero (registered state only)
// ----------------------------------------------------------------------------
module ysyx_regfile_sb
    import ysyx_regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NR_RD*AW-1:0]     rs_addr,
    output logic [NR_RD*DATA_W-1:0] rs_data,
    output logic [NR_RD-1:0]        rs_busy,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_rd,
    output logic                    iss_ready,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_rd,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    flush,
    output logic                    sb_idle
);

    reg_data_t         rf_q [NR_REG];
    sb_cnt_t           cnt_w [NR_REG];
    logic [NR_REG-1:0] busy_w;
    logic [NR_REG-1:0] full_w;
    logic              iss_acc;

    // ------------------------------------------------------------------
    // Register storage: single write port, reg 0 never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_valid && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Issue handshake. A full register may still accept an issue when a
    // writeback to it retires one writer in the same cycle.
    // ------------------------------------------------------------------
    assign iss_ready = !flush &&
                       ((iss_rd == '0) || !full_w[iss_rd] ||
                        (wb_valid && (wb_rd == iss_rd)));
    assign iss_acc   = iss_valid && iss_ready;

    // ------------------------------------------------------------------
    // Scoreboard counters, one per non-zero register.
    // ------------------------------------------------------------------
    assign cnt_w[0]  = '0;
    assign busy_w[0] = 1'b0;
    assign full_w[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NR_REG; gi++) begin : g_cnt
            logic inc_w;
            logic dec_w;

            assign inc_w = iss_acc  && (iss_rd == reg_addr_t'(gi));
            assign dec_w = wb_valid && (wb_rd  == reg_addr_t'(gi));

            ysyx_sb_counter u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc_w),
                .dec   (dec_w),
                .flush (flush),
                .cnt   (cnt_w[gi]),
                .busy  (busy_w[gi]),
                .full  (full_w[gi])
            );
        end
    endgenerate

    assign sb_idle = ~|busy_w;

    // ------------------------------------------------------------------
    // Read ports with writeback bypass. On a bypass hit the value is the
    // one being written, so the port is busy only if another writer
    // remains after this one retires.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
            reg_addr_t addr_w;
            reg_data_t data_w;
            logic      busy_rd_w;
            sb_cnt_t   cnt_left_w;

            assign addr_w     = rs_addr[gi*AW +: AW];
            assign cnt_left_w = cnt_w[addr_w] - CNT_ONE;

            always_comb begin
                data_w    = '0;
                busy_rd_w = 1'b0;
                if (addr_w != '0) begin
                    if (wb_valid && (wb_rd == addr_w)) begin
                        data_w    = wb_data;
                        busy_rd_w = (cnt_left_w != '0);
                    end else begin
                        data_w    = rf_q[addr_w];
                        busy_rd_w = busy_w[addr_w];
                    end
                end
            end

            assign rs_data[gi*DATA_W +: DATA_W] = data_w;
            assign rs_busy[gi]                  = busy_rd_w;
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_regfile_sb.sv
module tb_ysyx_regfile_sb;
    import ysyx_regfile_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NR_RD*AW-1:0]     rs_addr;
    logic [NR_RD*DATA_W-1:0] rs_data;
    logic [NR_RD-1:0]        rs_busy;
    logic                    iss_valid;
    logic [AW-1:0]           iss_rd;
    logic                    iss_ready;
    logic                    wb_valid;
    logic [AW-1:0]           wb_rd;
    logic [DATA_W-1:0]       wb_data;
    logic                    flush;
    logic                    sb_idle;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register values plus number of pending writers.
    logic [DATA_W-1:0] m_rf [NR_REG];
    int                m_pend [NR_REG];
    localparam int MAXW = (1 << CNT_W) - 1;

    always #5 clk = ~clk;

    ysyx_regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .sb_idle   (sb_idle)
    );

    function automatic logic m_ready();
        if (flush) return 1'b0;
        return (iss_rd == 0) || (m_pend[iss_rd] < MAXW) || (wb_valid && wb_rd == iss_rd);
    endfunction

    function automatic logic [DATA_W-1:0] m_data(input int a);
        if (a == 0) return '0;
        if (wb_valid && wb_rd == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic m_busy(input int a);
        if (a == 0) return 1'b0;
        if (wb_valid && wb_rd == a) return (m_pend[a] - 1) > 0;
        return m_pend[a] > 0;
    endfunction

    function automatic logic m_idle();
        for (int r = 0; r < NR_REG; r++) if (m_pend[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock: update the model from the driven inputs, then step.
    task automatic tick();
        logic acc;
        acc = iss_valid && m_ready();
        if (rst) begin
            for (int r = 0; r < NR_REG; r++) begin
                m_rf[r] = '0;
                m_pend[r] = 0;
            end
        end else begin
            if (wb_valid && wb_rd != 0) begin
                m_rf[wb_rd] = wb_data;
                if (m_pend[wb_rd] > 0) m_pend[wb_rd]--;
            end
            if (flush) begin
                for (int r = 0; r < NR_REG; r++) m_pend[r] = 0;
            end else if (acc && iss_rd != 0) begin
                m_pend[iss_rd]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; iss_valid = 0; iss_rd = '0; wb_valid = 0; wb_rd = '0;
        wb_data = '0; flush = 0; rs_addr = '0;
    endtask

    task automatic set_rs(input int p0, input int p1);
        rs_addr[0*AW +: AW] = AW'(p0);
        rs_addr[1*AW +: AW] = AW'(p1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        set_rs(0, 5);
        iss_rd = AW'(5);
        #1;
        n_checks++;
        if (rs_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", rs_data); end
        n_checks++;
        if (rs_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b want 00", rs_busy); end
        n_checks++;
        if (sb_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", sb_idle); end
        n_checks++;
        if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", iss_ready); end
        $display("test_reset: data=%h busy=%b idle=%b ready=%b", rs_data, rs_busy, sb_idle, iss_ready);
    endtask

    task automatic test_issue_wb();
        idle_inputs();
        iss_valid = 1; iss_rd = AW'(5);
        tick();
        idle_inputs();
        set_rs(5, 0);
        #1;
        n_checks++;
        if (rs_busy[0] !== 1'b1) begin n_fail++; $display("FAIL iss_busy got %b want 1", rs_busy[0]); end
        n_checks++;
        if (sb_idle !== 1'b0) begin n_fail++; $display("FAIL iss_idle got %b want 0", sb_idle); end
        wb_valid = 1; wb_rd = AW'(5); wb_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (rs_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_data got %h want deadbeef", rs_data[31:0]); end
        n_checks++;
        if (rs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got %b want 0", rs_busy[0]); end
        tick();
        wb_valid = 0;
        #1;
        n_checks++;
        if (sb_idle !== 1'b1) begin n_fail++; $display("FAIL wb_idle got %b want 1", sb_idle); end
        n_checks++;
        if (rs_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_stored got %h want deadbeef", rs_data[31:0]); end
        $display("test_issue_wb: rf[5]=%h idle=%b", rs_data[31:0], sb_idle);
    endtask

    task automatic test_saturation();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1; iss_rd = AW'(7);
            #1;
            n_checks++;
            if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sat_fill%0d got %b want 1", k, iss_ready); end
            tick();
        end
        iss_valid = 0;
        #1;
        n_checks++;
        if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full7 got %b want 0", iss_ready); end
        iss_rd = AW'(8);
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sat_free8 got %b want 1", iss_ready); end
        iss_valid = 1; iss_rd = AW'(7);
        wb_valid = 1; wb_rd = AW'(7); wb_data = 32'h0000_0777;
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sat_swap got %b want 1", iss_ready); end
        tick();
        idle_inputs();
        set_rs(7, 0);
        iss_rd = AW'(7);
        #1;
        n_checks++;
        if (iss_ready !== 1'b0 || rs_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sat_stay3 got ready=%b busy=%b want 0 1", iss_ready, rs_busy[0]);
        end
        // Drain three writers.
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1; wb_rd = AW'(7); wb_data = 32'(k + 1);
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (sb_idle !== 1'b1) begin n_fail++; $display("FAIL sat_drain got %b want 1", sb_idle); end
        $display("test_saturation: idle=%b", sb_idle);
    endtask

    task automatic test_reg0();
        idle_inputs();
        iss_valid = 1; iss_rd = '0;
        wb_valid = 1; wb_rd = '0; wb_data = 32'h1234;
        set_rs(0, 0);
        #1;
        n_checks++;
        if (rs_data !== '0 || rs_busy !== 2'b00) begin
            n_fail++; $display("FAIL reg0_read got %h/%b want 0/00", rs_data, rs_busy);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (sb_idle !== 1'b1 || rs_data !== '0) begin
            n_fail++; $display("FAIL reg0_after got idle=%b data=%h want 1/0", sb_idle, rs_data);
        end
        $display("test_reg0: data=%h idle=%b", rs_data, sb_idle);
    endtask

    task automatic test_flush();
        idle_inputs();
        iss_valid = 1; iss_rd = AW'(3); tick();
        iss_rd = AW'(4); tick();
        idle_inputs();
        flush = 1; iss_valid = 1; iss_rd = AW'(9);
        wb_valid = 1; wb_rd = AW'(3); wb_data = 32'h55;
        #1;
        n_checks++;
        if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", iss_ready); end
        tick();
        idle_inputs();
        set_rs(3, 9);
        #1;
        n_checks++;
        if (sb_idle !== 1'b1) begin n_fail++; $display("FAIL flush_idle got %b want 1", sb_idle); end
        n_checks++;
        if (rs_data[31:0] !== 32'h55 || rs_busy !== 2'b00) begin
            n_fail++; $display("FAIL flush_wb got %h busy=%b want 55 00", rs_data[31:0], rs_busy);
        end
        $display("test_flush: rf[3]=%h busy=%b idle=%b", rs_data[31:0], rs_busy, sb_idle);
    endtask

    task automatic test_rst_mid();
        idle_inputs();
        iss_valid = 1; iss_rd = AW'(6); tick();
        idle_inputs();
        rst = 1; wb_valid = 1; wb_rd = AW'(6); wb_data = 32'hFF;
        tick();
        idle_inputs();
        set_rs(6, 3);
        #1;
        n_checks++;
        if (rs_data !== '0 || rs_busy !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_read got %h/%b want 0/00", rs_data, rs_busy);
        end
        n_checks++;
        if (sb_idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got %b want 1", sb_idle); end
        $display("test_rst_mid: data=%h idle=%b", rs_data, sb_idle);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int p0, p1, pick;
            idle_inputs();
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 39) == 0);
            p0 = $urandom_range(0, NR_REG - 1);
            p1 = ($urandom_range(0, 3) == 0) ? p0 : $urandom_range(0, NR_REG - 1);
            set_rs(p0, p1);
            iss_valid = $urandom_range(0, 1);
            iss_rd = AW'($urandom_range(0, 7));
            // Writebacks only retire writers the model knows about (or hit reg 0).
            pick = -1;
            if ($urandom_range(0, 1) == 1) begin
                int start;
                start = $urandom_range(1, NR_REG - 1);
                for (int k = 0; k < NR_REG - 1; k++) begin
                    int r;
                    r = 1 + ((start - 1 + k) % (NR_REG - 1));
                    if (pick < 0 && m_pend[r] > 0) pick = r;
                end
                if (pick < 0 && $urandom_range(0, 7) == 0) pick = 0;
            end
            if (pick >= 0) begin
                wb_valid = 1; wb_rd = AW'(pick); wb_data = $urandom;
            end
            #1;
            n_checks++;
            if (rs_data[31:0] !== m_data(p0) || rs_data[63:32] !== m_data(p1)) begin
                n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h%h", cyc, rs_data, m_data(p1), m_data(p0));
            end
            n_checks++;
            if (rs_busy !== {m_busy(p1), m_busy(p0)}) begin
                n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b%b", cyc, rs_busy, m_busy(p1), m_busy(p0));
            end
            n_checks++;
            if (iss_ready !== m_ready()) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, iss_ready, m_ready());
            end
            n_checks++;
            if (sb_idle !== m_idle()) begin
                n_fail++; $display("FAIL rnd_idle cyc %0d got %b want %b", cyc, sb_idle, m_idle());
            end
            tick();
        end
        $display("test_random: 3000 cycles, %0d new failures", n_fail - errs_before);
    endtask

    initial begin
        for (int r = 0; r < NR_REG; r++) begin
            m_rf[r] = '0;
            m_pend[r] = 0;
        end
        idle_inputs();
        test_reset();
        test_issue_wb();
        test_saturation();
        test_reg0();
        test_flush();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
